// File: rtl/int_sqrt_seq.sv
// Sequential integer square root: restoring digit-by-digit, one root bit per clock,
// valid/ready handshake on both sides. Define INT_SQRT_ROUND_EN for round-to-nearest root.
module int_sqrt_seq #(
  parameter  int IN_WIDTH  = 16,
  localparam int OUT_WIDTH = IN_WIDTH / 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [IN_WIDTH-1:0]  dataIn,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [OUT_WIDTH-1:0] root,
  output logic [OUT_WIDTH:0]   rem
);

  // Partial remainder never exceeds 2*partial_root, so OUT_WIDTH+1 bits hold it;
  // the shifted trial value needs two more bits on top of that.
  localparam int RW = OUT_WIDTH + 1;
  localparam int AW = OUT_WIDTH + 3;
  localparam int CW = $clog2(OUT_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic [IN_WIDTH-1:0]   x_q;
  logic [RW-1:0]         acc_q;
  logic [OUT_WIDTH-1:0]  q_q;
  logic [CW-1:0]         cnt;

  logic [AW-1:0]         acc_shift;
  logic [AW-1:0]         acc_trial;
  logic                  fits;
  logic [RW-1:0]         rem_next;
  logic [OUT_WIDTH-1:0]  q_next;
  logic [OUT_WIDTH-1:0]  root_fin;

  // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
  always_comb begin
    acc_shift = {acc_q, x_q[IN_WIDTH-1 -: 2]};
    acc_trial = {1'b0, q_q, 2'b01};
    fits      = (acc_shift >= acc_trial);
    rem_next  = RW'(fits ? (acc_shift - acc_trial) : acc_shift);
    q_next    = q_q << 1;
    q_next[0] = fits;
    root_fin  = q_next;
`ifdef INT_SQRT_ROUND_EN
    // Round up when the remainder passes the midpoint, holding at the top code.
    if ((rem_next > {1'b0, q_next}) && (q_next != '1))
      root_fin = q_next + 1'b1;
`endif
  end

  // NOTE: all state uses non-blocking assignments, and every register (datapath
  // included) is cleared by reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      root     <= '0;
      rem      <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid && inReady) begin
            x_q     <= dataIn;
            acc_q   <= '0;
            q_q     <= '0;
            cnt     <= '0;
            inReady <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          x_q   <= x_q << 2;
          acc_q <= rem_next;
          q_q   <= q_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(OUT_WIDTH - 1)) begin
            root     <= root_fin;
            rem      <= rem_next;
            outValid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE first means a new radicand is never taken on the consuming edge.
          if (outReady) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/int_sqrt_seq.md
INT_SQRT_SEQ -- requirements
Module: int_sqrt_seq

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 16, giving the radicand width; it must be even and at least 2.
REQ-002 The block SHALL have localparam OUT_WIDTH = IN_WIDTH/2, giving the root width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port inValid, input, 1 bit: radicand present.
REQ-006 The block SHALL have port inReady, output, 1 bit: block can accept a radicand.
REQ-007 The block SHALL have port dataIn, input, IN_WIDTH bits: unsigned radicand.
REQ-008 The block SHALL have port outValid, output, 1 bit: result present.
REQ-009 The block SHALL have port outReady, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port root, output, OUT_WIDTH bits: unsigned square root.
REQ-011 The block SHALL have port rem, output, OUT_WIDTH+1 bits: dataIn - floor(sqrt)^2.

Function
REQ-012 The FSM SHALL have three states, IDLE, CALC and DONE, with these transitions:
- IDLE->CALC on inValid&&inReady.
- CALC->DONE after OUT_WIDTH iterations.
- DONE->IDLE on outValid&&outReady.
REQ-013 inReady SHALL be 1 only in IDLE, and outValid SHALL be 1 only in DONE; neither output is combinationally dependent on any input.
REQ-014 dataIn SHALL be captured on the accepting edge; later changes to dataIn SHALL NOT affect the result.
REQ-015 The root SHALL be computed by the restoring digit-by-digit method, one root bit per clock edge, MSB first, over exactly OUT_WIDTH CALC edges.
REQ-016 Latency: if the accepting edge is edge 0, outValid SHALL be 1 after edge OUT_WIDTH (8 cycles for the default).
REQ-017 Without rounding, root SHALL equal floor(sqrt(dataIn)) and rem SHALL equal dataIn - root^2, with 0 <= rem <= 2*root.
REQ-018 Internal trial subtraction SHALL be at least OUT_WIDTH+2 bits wide so that no intermediate overflows for any dataIn, including all-ones.
REQ-019 root and rem SHALL be registered, and SHALL hold stable throughout DONE until the handshake completes (backpressure).
REQ-020 In DONE, inValid SHALL be ignored; no new input is accepted on the same edge that a result is consumed, so the throughput is one result per OUT_WIDTH+2 cycles minimum.
REQ-021 dataIn = 0 SHALL give root = 0 and rem = 0 with normal latency; no fast path is allowed.

Reset
REQ-022 On rst_n low, the block SHALL immediately, without waiting for clk, go to IDLE with inReady=1 (after reset), outValid=0, root=0, rem=0, and all internal registers 0.
REQ-023 Reset asserted in CALC or DONE SHALL abort the operation; the pending result is discarded and never presented.
REQ-024 After rst_n deassertion, the first accepting edge SHALL be the first clk edge with inValid=1.

Configuration
REQ-025 The macro INT_SQRT_ROUND_EN SHALL select round-to-nearest output.
REQ-026 With INT_SQRT_ROUND_EN defined, root SHALL be the truncated root +1 when the truncated rem > the truncated root, and SHALL saturate at 2^OUT_WIDTH-1.
REQ-027 With INT_SQRT_ROUND_EN defined, rem SHALL still report the truncated remainder, and latency SHALL be unchanged.
REQ-028 With INT_SQRT_ROUND_EN undefined, root SHALL be truncated per REQ-017, and the rounding logic SHALL be absent.

Verification
REQ-029 Default params, dataIn=1234 with outReady=1 -> after 8 cycles, root=35 and rem=9; outValid SHALL stay high for 1 cycle.
REQ-030 dataIn=0, then dataIn=65535 -> root=0/rem=0, then root=255/rem=510; inReady SHALL be 0 for the whole of each operation.
REQ-031 dataIn=1234 with outReady held 0 for 20 cycles and dataIn toggled meanwhile -> root=35/rem=9 stable; outValid=1 throughout; inReady=0 throughout.
REQ-032 rst_n pulsed low at CALC cycle 4 of dataIn=40000, then dataIn=144 applied -> no result for 40000; root=12/rem=0 at normal latency.
REQ-033 INT_SQRT_ROUND_EN defined: dataIn 1260 -> root 35; 1261 -> root 36 (rem 36); 65535 -> root 255 (saturated).
REQ-034 Random sweep of 10k values with random backpressure -> every result SHALL match the reference model root^2 <= x < (root+1)^2, with no lost or duplicated results.
